// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin OR arbiter.
//
// Contents:
//   ST_IDLE / ST_CALC / ST_RESP : 2-bit sequencer state codes (2'b11 unused)
//   MAX_REQ / IDX_W             : upper bound on requesters and index width
//   onehot(idx)                 : MAX_REQ-bit one-hot vector for an index
//   rr_pick(req, ptr, n)        : first requester at or after ptr, wrapping
//                                 at n-1 -> 0
package arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_CALC = 2'b01;
    localparam state_t ST_RESP = 2'b10;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Circular priority search. req is zero-padded above n, so only the
    // first n offsets are examined. If nothing is requesting, ptr is
    // returned; callers only use the result when req is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [IDX_W-1:0] w;
        logic             found;
        int               j;
        w     = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if (k < n && !found && req[j[IDX_W-1:0]]) begin
                w     = j[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/unidade_or_reg.sv
// Shared WIDTH-bit OR unit with a registered output.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears y
//   en    : load a|b into y on the next rising edge
//   a, b  : operands
//   y     : registered result, holds its value while en is low
module unidade_or_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;

    always_comb begin
        y_d = y_q;
        if (en) begin
            y_d = a | b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/arbitro_or_rr.sv
// Round-robin arbiter/sequencer in front of a single shared OR unit.
//
// Each transaction takes three cycles: IDLE (arbitrate and latch operands),
// CALC (shared unit registers a|b), RESP (valid pulse, advance pointer).
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   req   : per-requester request, sampled only in IDLE
//   op_a  : operand A, requester i at [i*WIDTH +: WIDTH]
//   op_b  : operand B, same packing
//   gnt   : one-hot grant, asserted in CALC and RESP
//   busy  : high whenever the sequencer is not in IDLE
//   valid : one-cycle pulse in RESP, y holds the granted requester's result
//   y     : result register, holds the last result between transactions
//
// Build option:
//   ARB_FIXED_PRIO_EN : when defined, the lowest requesting index always wins
//                       and the round-robin pointer stays at 0.
module arbitro_or_rr
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   valid,
    output logic [WIDTH-1:0]       y
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] w_q, w_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH-1:0]   a_lane [N_REQ];
    logic [WIDTH-1:0]   b_lane [N_REQ];
    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   pick;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               active;

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign a_lane[gi] = op_a[gi*WIDTH +: WIDTH];
        assign b_lane[gi] = op_b[gi*WIDTH +: WIDTH];
    end

    // Winner selection and operand mux.
    always_comb begin
        req_ext            = '0;
        req_ext[N_REQ-1:0] = req;
`ifdef ARB_FIXED_PRIO_EN
        pick = rr_pick(req_ext, '0, N_REQ);
`else
        pick = rr_pick(req_ext, ptr_q, N_REQ);
`endif
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                a_sel = a_lane[i];
                b_sel = b_lane[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    w_d     = pick;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
`ifdef ARB_FIXED_PRIO_EN
                ptr_d = '0;
`else
                // The winner just served drops to lowest priority.
                ptr_d = (w_q == IDX_W'(N_REQ - 1)) ? '0 : w_q + IDX_W'(1);
`endif
                state_d = ST_IDLE;
            end
            default: begin
                // Unused encoding 2'b11 falls back to IDLE.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Single shared OR unit; it only loads while in CALC.
    unidade_or_reg #(
        .WIDTH (WIDTH)
    ) u_or (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_CALC),
        .a     (a_q),
        .b     (b_q),
        .y     (y)
    );

    assign active = (state_q == ST_CALC) || (state_q == ST_RESP);
    assign gnt    = active ? N_REQ'(onehot(w_q)) : '0;
    assign busy   = (state_q != ST_IDLE);
    assign valid  = (state_q == ST_RESP);

endmodule

// File: tb/tb_arbitro_or_rr.sv
module tb_arbitro_or_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   op_a;
    logic [N*W-1:0]   op_b;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             valid;
    logic [W-1:0]     y;

    arbitro_or_rr #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op_a  (op_a),
        .op_b  (op_b),
        .gnt   (gnt),
        .busy  (busy),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: where in the 3-cycle transaction we are,
    // who is being served, and the priority pointer.
    int m_phase = 0;
    int m_w     = 0;
    int m_ptr   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pick_winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Model: observes the stimulus at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_ptr   = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    if (req != '0) begin
                        exp_t e;
`ifdef ARB_FIXED_PRIO_EN
                        m_w = pick_winner(req, 0);
`else
                        m_w = pick_winner(req, m_ptr);
`endif
                        e.idx = m_w;
                        e.res = op_a[m_w*W +: W] | op_b[m_w*W +: W];
                        exp_q.push_back(e);
                        m_phase = 1;
                    end
                end
                1: m_phase = 2;
                default: begin
                    m_phase = 0;
`ifdef ARB_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (m_w + 1) % N;
`endif
                end
            endcase
        end
    end

    // Monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt",   32'(gnt),   32'h0);
            chk("rst_busy",  32'(busy),  32'h0);
            chk("rst_valid", 32'(valid), 32'h0);
            chk("rst_y",     32'(y),     32'h0);
        end else begin
            chk("busy",  32'(busy),  32'(m_phase != 0));
            chk("valid", 32'(valid), 32'(m_phase == 2));
            chk("gnt",   32'(gnt),   (m_phase != 0) ? (32'h1 << m_w) : 32'h0);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn requester=%0d y=%h expected=%h", e.idx, y, e.res);
                    chk("y",       32'(y),   32'(e.res));
                    chk("gnt_txn", 32'(gnt), 32'h1 << e.idx);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        req   = '1;
        op_a  = '0;
        op_b  = '0;
        for (int i = 0; i < N; i++) set_lane(i, W'(8'h10 << i), W'(i + 1));
        repeat (3) step();
        rst_n = 1'b1;
        // Requests held through reset release: first grant goes to 0.
        repeat (6) step();

        // Single request with mid-transaction operand change and req drop.
        do_reset(2);
        req = 4'b0100;
        set_lane(2, 8'hA0, 8'h05);
        step();
        req = '0;
        set_lane(2, 8'hFF, 8'hFF);
        repeat (4) step();

        // Fairness: everyone requests with distinct operands.
        do_reset(2);
        for (int i = 0; i < N; i++) set_lane(i, W'(8'h11 * (i + 1)), W'(8'h80 >> i));
        req = '1;
        repeat (16) step();

        // Wrap: serve requester 2, then 3 and 0 are both pending.
        req = '0;
        repeat (4) step();
        do_reset(2);
        req = 4'b0100;
        step();
        req = 4'b1001;
        repeat (9) step();

        // Reset during CALC: the in-flight transaction is dropped.
        req = '0;
        repeat (4) step();
        req = 4'b0010;
        set_lane(1, 8'h3C, 8'hC3);
        waited = 0;
        while (m_phase != 1 && waited < 20) begin
            step();
            waited++;
        end
        chk("wait_calc_timeout", 32'(waited < 20), 32'h1);
        rst_n = 1'b0;
        req   = '0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // Randomized traffic with occasional operand churn and resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) set_lane(i, W'($urandom), W'($urandom));
            end
            if ($urandom_range(0, 149) == 0) begin
                do_reset(2);
            end else begin
                step();
            end
        end

        // Drain: every accepted transaction must have produced a result.
        req = '0;
        repeat (6) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
